// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 16x-oversampling UART receiver with valid/ready output and sticky error flags.
// Optional even-parity framing is enabled with the UART_RX_PARITY_EN macro.
module uart_rx_oversample #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DIV        = CLK_HZ / (BAUD * OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err
`ifdef UART_RX_PARITY_EN
    ,output logic      parity_err
`endif
);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic          rx_m_q, rx_s_q;
    logic [DW-1:0] div_q;
    logic [3:0]    scnt_q, scnt_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          s7_q, s7_d, s8_q, s8_d;
    logic [7:0]    sh_q, sh_d;
    logic          armed_q, armed_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic          perr_q, perr_d;
`endif
    logic          tick, maj, at9, at15;

    assign tick = div_q == DW'(DIV - 1);
    assign maj  = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
    assign at9  = tick && scnt_q == 4'd9;
    assign at15 = tick && scnt_q == 4'd15;

    // Input synchronizer and free-running sample-tick divider
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
            div_q  <= '0;
        end else begin
            rx_m_q <= rx;
            rx_s_q <= rx_m_q;
            div_q  <= tick ? '0 : div_q + DW'(1);
        end
    end

    // Frame FSM next state, majority sampling, handshake and error flags
    always_comb begin
        state_d  = state_q;
        scnt_d   = tick ? scnt_q + 4'd1 : scnt_q;
        bitcnt_d = bitcnt_q;
        s7_d     = (tick && scnt_q == 4'd7) ? rx_s_q : s7_q;
        s8_d     = (tick && scnt_q == 4'd8) ? rx_s_q : s8_q;
        sh_d     = sh_q;
        armed_d  = armed_q | (state_q == IDLE && rx_s_q);
        data_d   = data_q;
        valid_d  = valid_q & ~ready;
        ferr_d   = ferr_q & ~clr_err;
        ovr_d    = ovr_q & ~clr_err;
`ifdef UART_RX_PARITY_EN
        perr_d   = perr_q & ~clr_err;
`endif
        case (state_q)
            IDLE: begin
                if (tick && armed_q && !rx_s_q) begin
                    state_d = START;
                    scnt_d  = 4'd0;
                end
            end
            START: begin
                if (at9 && maj) begin
                    state_d = IDLE;
                end else if (at15) begin
                    state_d  = DATA;
                    bitcnt_d = 3'd0;
                end
            end
            DATA: begin
                if (at9) sh_d[bitcnt_q] = maj;
                if (at15) begin
                    bitcnt_d = bitcnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bitcnt_q == 3'd7) state_d = PARITY;
`else
                    if (bitcnt_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at9 && ^{sh_q, maj}) perr_d = 1'b1;
                if (at15) state_d = STOP;
            end
`endif
            STOP: begin
                if (at9) begin
                    state_d = IDLE;
                    if (maj && (!valid_q || ready)) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                    end else if (maj) begin
                        ovr_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            scnt_q   <= 4'd0;
            bitcnt_q <= 3'd0;
            s7_q     <= 1'b1;
            s8_q     <= 1'b1;
            sh_q     <= 8'd0;
            armed_q  <= 1'b0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            bitcnt_q <= bitcnt_d;
            s7_q     <= s7_d;
            s8_q     <= s8_d;
            sh_q     <= sh_d;
            armed_q  <= armed_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign busy      = state_q != IDLE;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: directed frames at 864 clks/bit against uart_rx_oversample.
module tb_uart_rx_oversample;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic       clr_err = 1'b0;
    logic [7:0] data;
    logic       valid, busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       pflip = 1'b0;
`endif

    int         total = 0;
    int         passed = 0;
    int         pulses = 0;
    int         vcyc = 0;
    logic [7:0] last = 8'd0;
    logic       pv = 1'b0;

    uart_rx_oversample dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx(rx),
        .data(data),
        .valid(valid),
        .ready(ready),
        .busy(busy),
        .frame_err(frame_err),
        .overrun(overrun),
        .clr_err(clr_err)
`ifdef UART_RX_PARITY_EN
        ,.parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Counts valid-high cycles and valid rising edges, capturing data at each rise
    always @(negedge clk) begin
        if (valid) vcyc <= vcyc + 1;
        if (valid && !pv) begin
            pulses <= pulses + 1;
            last   <= data;
        end
        pv <= valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        wait_clks(864);
    endtask

    task automatic send(input logic [7:0] b, input logic sb);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(^b ^ pflip);
`endif
        bit_time(sb);
    endtask

    initial begin
        wait_clks(3);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        reset_n = 1'b1;
        wait_clks(864);

        send(8'h55, 1'b1);
        check("b55_pulses", pulses, 1);
        check("b55_vcyc", vcyc, 1);
        check("b55_data", last, 8'h55);
        check("b55_ferr", frame_err, 0);
        check("b55_busy", busy, 0);

        rx = 1'b0;
        wait_clks(200);
        check("glitch_busy", busy, 1);
        wait_clks(100);
        rx = 1'b1;
        wait_clks(864);
        check("glitch_idle", busy, 0);
        check("glitch_pulses", pulses, 1);
        check("glitch_ferr", frame_err, 0);

        send(8'hA3, 1'b0);
        rx = 1'b0;
        wait_clks(20 * 864);
        check("brk_ferr", frame_err, 1);
        check("brk_pulses", pulses, 1);
        check("brk_busy", busy, 0);
        bit_time(1'b1);
        send(8'h0F, 1'b1);
        check("b0f_data", last, 8'h0F);
        check("b0f_pulses", pulses, 2);
        check("b0f_vcyc", vcyc, 2);
        check("b0f_ferr_sticky", frame_err, 1);
        clr_err = 1'b1;
        wait_clks(1);
        clr_err = 1'b0;
        check("clr_ferr", frame_err, 0);

        ready = 1'b0;
        send(8'h11, 1'b1);
        check("b11_valid", valid, 1);
        check("b11_ovr", overrun, 0);
        send(8'h22, 1'b1);
        check("ovr_flag", overrun, 1);
        check("ovr_data", data, 8'h11);
        check("ovr_pulses", pulses, 3);
        ready = 1'b1;
        check("ovr_valid_held", valid, 1);
        wait_clks(1);
        check("ovr_valid_drop", valid, 0);

        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        wait_clks(400);
        check("rstmid_busy", busy, 1);
        reset_n = 1'b0;
        wait_clks(2);
        check("rstmid_data", data, 0);
        check("rstmid_valid", valid, 0);
        check("rstmid_busy0", busy, 0);
        check("rstmid_ovr", overrun, 0);
        reset_n = 1'b1;
        wait_clks(2 * 864);
        send(8'h3C, 1'b1);
        check("b3c_data", last, 8'h3C);
        check("b3c_pulses", pulses, 4);
        check("b3c_ferr", frame_err, 0);
        check("b3c_ovr", overrun, 0);

`ifdef UART_RX_PARITY_EN
        pflip = 1'b1;
        send(8'h07, 1'b1);
        check("par_bad_err", parity_err, 1);
        check("par_bad_data", last, 8'h07);
        check("par_bad_pulses", pulses, 5);
        clr_err = 1'b1;
        wait_clks(1);
        clr_err = 1'b0;
        check("par_clr", parity_err, 0);
        pflip = 1'b0;
        send(8'h07, 1'b1);
        check("par_ok_err", parity_err, 0);
        check("par_ok_pulses", pulses, 6);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
